// File: rtl/ncc_pkg.sv
// Shared types and constants for the NCC peak finder.
// Optional threshold feature in the top is enabled by NCC_PEAK_THRESH_EN.
package ncc_pkg;

    localparam int WIN_DIM  = 640;
    localparam int DESC_DIM = 16;
    localparam int LANES    = 16;
    localparam int SCORE_W  = 8;

    localparam int NPOS          = WIN_DIM - DESC_DIM + 1;
    localparam int BEATS_PER_ROW = (NPOS + LANES - 1) / LANES;
    localparam int POS_W         = $clog2(NPOS);

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } state_t;

    // Most negative score; used for masked lanes and as the "nothing seen yet" best.
    localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

endpackage

// File: rtl/lane_max_tree.sv
// Combinational 16-to-1 signed maximum with lowest-lane-index tie-break.
module lane_max_tree
    import ncc_pkg::*;
(
    input  logic [LANES*SCORE_W-1:0] scores_i,
    output score_t                   max_o,
    output logic [3:0]               idx_o
);

    score_t     val [LANES];
    logic [3:0] idx [LANES];

    // Pairwise reduction; the left (lower-index) entry survives unless the right one is strictly larger.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            val[i] = score_t'(scores_i[i*SCORE_W +: SCORE_W]);
            idx[i] = 4'(i);
        end
        for (int s = 1; s < LANES; s = s * 2) begin
            for (int i = 0; i < LANES; i = i + 2 * s) begin
                if (val[i+s] > val[i]) begin
                    val[i] = val[i+s];
                    idx[i] = idx[i+s];
                end
            end
        end
        max_o = val[0];
        idx_o = idx[0];
    end

endmodule

// File: rtl/ncc_peak_finder.sv
// Tracks the global maximum NCC score and its (x, y) over one raster-scanned search window.
// Define NCC_PEAK_THRESH_EN to add the score_thresh_i input and peak_found_o output.
module ncc_peak_finder
    import ncc_pkg::*;
#(
    parameter int WinDim  = WIN_DIM,
    parameter int DescDim = DESC_DIM,
    localparam int NPos        = WinDim - DescDim + 1,
    localparam int BeatsPerRow = (NPos + LANES - 1) / LANES,
    localparam int PosW        = $clog2(NPos)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     score_valid_i,
    output logic                     score_ready_o,
    input  logic [LANES*SCORE_W-1:0] score_in_i,
    output logic                     result_valid_o,
    input  logic                     result_ack_i,
    output logic [SCORE_W-1:0]       best_score_o,
    output logic [PosW-1:0]          best_x_o,
    output logic [PosW-1:0]          best_y_o,
`ifdef NCC_PEAK_THRESH_EN
    input  logic [SCORE_W-1:0]       score_thresh_i,
    output logic                     peak_found_o,
`endif
    output logic                     busy_o
);

    state_t                   state_q, state_d;
    logic                     flushCnt_q, flushCnt_d;
    logic [PosW-1:0]          beat_q, row_q;
    logic                     accept, lastBeat, lastRow, startIdle;
    logic [LANES*SCORE_W-1:0] maskedScores;
    score_t                   laneMax;
    logic [3:0]               laneIdx;
    logic                     s1Valid_q;
    score_t                   s1Score_q;
    logic [PosW-1:0]          s1X_q, s1Y_q;
    score_t                   best_q;
    logic [PosW-1:0]          bestX_q, bestY_q;

    assign accept    = score_valid_i && (state_q == SCAN);
    assign lastBeat  = (beat_q == PosW'(BeatsPerRow - 1));
    assign lastRow   = (row_q == PosW'(NPos - 1));
    assign startIdle = start_i && (state_q == IDLE);

    // Frame sequencing: IDLE -> SCAN -> two drain cycles in FLUSH -> DONE until acknowledged.
    always_comb begin
        state_d    = state_q;
        flushCnt_d = 1'b0;
        unique case (state_q)
            IDLE:  if (start_i) state_d = SCAN;
            SCAN:  if (accept && lastBeat && lastRow) state_d = FLUSH;
            FLUSH: begin
                flushCnt_d = ~flushCnt_q;
                if (flushCnt_q) state_d = DONE;
            end
            DONE:  if (result_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register for the frame sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            flushCnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    // Lanes that fall past the last valid placement of a row are forced to the minimum score.
    always_comb begin
        maskedScores = score_in_i;
        for (int i = 0; i < LANES; i++) begin
            if ((int'(beat_q) * LANES + i) >= NPos) begin
                maskedScores[i*SCORE_W +: SCORE_W] = SCORE_MIN;
            end
        end
    end

    lane_max_tree uTree (
        .scores_i (maskedScores),
        .max_o    (laneMax),
        .idx_o    (laneIdx)
    );

    // Raster position of the current beat: beat within the row, then row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            row_q  <= '0;
        end else if (startIdle) begin
            beat_q <= '0;
            row_q  <= '0;
        end else if (accept) begin
            if (lastBeat) begin
                beat_q <= '0;
                row_q  <= row_q + PosW'(1);
            end else begin
                beat_q <= beat_q + PosW'(1);
            end
        end
    end

    // Stage 1: register the beat's best lane together with its window coordinates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Score_q <= SCORE_MIN;
            s1X_q     <= '0;
            s1Y_q     <= '0;
        end else begin
            s1Valid_q <= accept;
            if (accept) begin
                s1Score_q <= laneMax;
                s1X_q     <= PosW'(int'(beat_q) * LANES + int'(laneIdx));
                s1Y_q     <= row_q;
            end
        end
    end

    // Stage 2: strictly-greater update so the earliest raster position keeps ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q  <= SCORE_MIN;
            bestX_q <= '0;
            bestY_q <= '0;
        end else if (startIdle) begin
            best_q  <= SCORE_MIN;
            bestX_q <= '0;
            bestY_q <= '0;
        end else if (s1Valid_q && (s1Score_q > best_q)) begin
            best_q  <= s1Score_q;
            bestX_q <= s1X_q;
            bestY_q <= s1Y_q;
        end
    end

`ifdef NCC_PEAK_THRESH_EN
    logic peakFound_q;

    // Threshold verdict captured as the final best settles, on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peakFound_q <= 1'b0;
        end else if ((state_q == FLUSH) && flushCnt_q) begin
            peakFound_q <= (best_q >= score_t'(score_thresh_i));
        end
    end

    assign peak_found_o = peakFound_q;
`endif

    assign score_ready_o  = (state_q == SCAN);
    assign busy_o         = (state_q == SCAN) || (state_q == FLUSH);
    assign result_valid_o = (state_q == DONE);
    assign best_score_o   = best_q;
    assign best_x_o       = bestX_q;
    assign best_y_o       = bestY_q;

endmodule

// File: tb/tb_ncc_peak_finder.sv
// Self-checking bench for ncc_peak_finder on a reduced 64x64 window (49 placements, 4 beats per row).
// Define NCC_PEAK_THRESH_EN to also exercise the threshold output.
module tb_ncc_peak_finder;

    localparam int WIN = 64;
    localparam int DESC = 16;
    localparam int NP = WIN - DESC + 1;
    localparam int L = 16;
    localparam int BPR = (NP + L - 1) / L;
    localparam int PW = $clog2(NP);
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sv = 1'b0;
    logic ack = 1'b0;
    logic ready, rv, busy;
    logic [L*SW-1:0] sin = '0;
    logic [SW-1:0] bs;
    logic [PW-1:0] bx, by;
`ifdef NCC_PEAK_THRESH_EN
    logic [SW-1:0] thresh = 8'd60;
    logic peak;
`endif

    int checks = 0;
    int failures = 0;
    int mBest = -128;
    int mX = 0;
    int mY = 0;
    bit chkEn = 0;
    bit expReady = 0, expBusy = 0, expValid = 0, expBestChk = 0;

    always #5 clk = ~clk;

    ncc_peak_finder #(.WinDim(WIN), .DescDim(DESC)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .score_valid_i  (sv),
        .score_ready_o  (ready),
        .score_in_i     (sin),
        .result_valid_o (rv),
        .result_ack_i   (ack),
        .best_score_o   (bs),
        .best_x_o       (bx),
        .best_y_o       (by),
`ifdef NCC_PEAK_THRESH_EN
        .score_thresh_i (thresh),
        .peak_found_o   (peak),
`endif
        .busy_o         (busy)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the DUT against the bench's expectations.
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("score_ready", int'(ready), int'(expReady));
            checkOutput("busy", int'(busy), int'(expBusy));
            checkOutput("result_valid", int'(rv), int'(expValid));
            if (expBestChk) begin
                checkOutput("best_score", int'($signed(bs)), mBest);
                checkOutput("best_x", int'(bx), mX);
                checkOutput("best_y", int'(by), mY);
`ifdef NCC_PEAK_THRESH_EN
                if (expValid) checkOutput("peak_found", int'(peak), int'(mBest >= 60));
`endif
            end
        end
    end

    initial begin
        #400000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic int genScore(input int mode, input int x, input int y);
        if (x >= NP) return 127;
        case (mode)
            1: return (x == 37 && y == 42) ? 100 : -5;
            2: return ((x == 3 && y == 10) || (x == 40 && y == 45)) ? 77 : -5;
            3: return (y == 30 && (x == 20 || x == 25)) ? 77 : -5;
            4: return 0;
            5: return (x == 48 && y == 7) ? 50 : 0;
            6: return ((x * 7 + y * 13 + x * y) % 200) - 100;
            7: return (x == 10 && y == 10) ? 59 : -20;
            8: return (x == 10 && y == 10) ? 60 : -20;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setExp(input bit r, input bit b, input bit v, input bit bc);
        expReady = r;
        expBusy = b;
        expValid = v;
        expBestChk = bc;
    endtask

    task automatic modelReset();
        mBest = -128;
        mX = 0;
        mY = 0;
    endtask

    // Drive one beat and fold its in-window placements into the raster-order maximum.
    task automatic applyStimulus(input int mode, input int row, input int beat, input bit v);
        int s;
        sv = v;
        if (!v) begin
            sin = {L{8'h7F}};
        end else begin
            for (int i = 0; i < L; i++) begin
                s = genScore(mode, beat * L + i, row);
                sin[i*SW +: SW] = SW'(s);
                if (beat * L + i < NP && s > mBest) begin
                    mBest = s;
                    mX = beat * L + i;
                    mY = row;
                end
            end
        end
    endtask

    task automatic runFrame(input int mode, input bit randV, input bit midStart, input int abortAt,
                            input bit litEn, input int litS, input int litX, input int litY,
                            input bit ackWithStart);
        int row = 0, beat = 0, acc = 0;
        bit done = 0;
        bit v;
        tick();
        start = 1; ack = 0; sv = 1; sin = {L{8'h7F}};
        setExp(0, 0, 0, 0);
        tick();
        start = 0;
        modelReset();
        while (!done) begin
            setExp(1, 1, 0, 0);
            if (abortAt >= 0 && acc == abortAt) begin
                rst = 1; sv = 0;
                modelReset();
                setExp(0, 0, 0, 1);
                tick();
                rst = 0;
                for (int k = 0; k < 3; k++) tick();
                return;
            end
            v = randV ? 1'($urandom_range(0, 1)) : 1'b1;
            start = midStart && (acc == 60);
            applyStimulus(mode, row, beat, v);
            if (v) begin
                acc++;
                if (row == NP - 1 && beat == BPR - 1) done = 1;
                beat++;
                if (beat == BPR) begin
                    beat = 0;
                    row++;
                end
            end
            tick();
        end
        start = 0; sv = 1; sin = {L{8'h7F}};
        setExp(0, 1, 0, 0);
        tick();
        tick();
        setExp(0, 0, 1, 1);
        if (litEn) begin
            @(negedge clk);
            #1;
            checkOutput("lit_score", int'($signed(bs)), litS);
            checkOutput("lit_x", int'(bx), litX);
            checkOutput("lit_y", int'(by), litY);
            checkOutput("model_score", mBest, litS);
            checkOutput("model_xy", mX * 100 + mY, litX * 100 + litY);
        end
        tick();
        start = 1;
        tick();
        start = ackWithStart; ack = 1;
        tick();
        start = 0; ack = 0; sv = 0;
        setExp(0, 0, 0, 0);
        tick();
        ack = 1;
        tick();
        ack = 0;
    endtask

    initial begin
        $display("[TB] start");
        for (int k = 0; k < 3; k++) tick();
        rst = 0;
        modelReset();
        setExp(0, 0, 0, 1);
        chkEn = 1;
        for (int k = 0; k < 5; k++) tick();
        checkOutput("reset_best", int'($signed(bs)), -128);

        runFrame(1, 0, 0, -1, 1, 100, 37, 42, 0);
        runFrame(2, 0, 0, -1, 1, 77, 3, 10, 1);
        runFrame(3, 0, 0, -1, 1, 77, 20, 30, 0);
        runFrame(4, 0, 0, -1, 1, 0, 0, 0, 0);
        runFrame(5, 0, 0, -1, 1, 50, 48, 7, 1);
        runFrame(6, 1, 1, 100, 0, 0, 0, 0, 0);
        runFrame(6, 1, 1, -1, 0, 0, 0, 0, 1);
`ifdef NCC_PEAK_THRESH_EN
        runFrame(7, 0, 0, -1, 1, 59, 10, 10, 0);
        checkOutput("peak59", int'(peak), 0);
        runFrame(8, 1, 0, -1, 1, 60, 10, 10, 0);
        checkOutput("peak60", int'(peak), 1);
`endif
        tick();
        chkEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
